// File: rtl/ternary_seq_ctrl_pkg.sv
// Shared types and sizing for the ternary tile sequencer.
// Lane count drives both the output index width and the weight-load length.
package ternary_seq_ctrl_pkg;

    localparam int unsigned MAX_IN_LEN  = 16;
    localparam int unsigned MAX_OUT_LEN = 8;
    localparam int unsigned LOAD_CYCLES = 2 * MAX_OUT_LEN;
    localparam int unsigned VEC_W       = 8;
    localparam int unsigned DEF_MAC_LAT = 2;
    localparam int unsigned IDX_W       = $clog2(MAX_OUT_LEN);
    localparam int unsigned CNT_W       = $clog2(LOAD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_WAIT_IN = 3'd3,
        S_DRAIN   = 3'd4,
        S_EMIT    = 3'd5
    } seq_state_e;

    function automatic logic [VEC_W-1:0] sat_inc(input logic [VEC_W-1:0] v);
        return (v == '1) ? v : v + VEC_W'(1);
    endfunction

endpackage

// File: rtl/ternary_seq_ctrl_if.sv
// Pin-side bundle of the sequencer: control, loader, vector-in and result-out handshakes.
interface ternary_seq_ctrl_if;
    import ternary_seq_ctrl_pkg::*;

    logic             ena;
    logic             start;
    logic             reload;
    logic [VEC_W-1:0] cfg_num_vec;
    logic             load_en;
    logic             load_done;
    logic             in_valid;
    logic             in_ready;
    logic             mac_en;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             weights_valid;
    logic             busy;
    logic             err;
    logic [VEC_W-1:0] vec_cnt;

    modport slave (
        input  ena, start, reload, cfg_num_vec, load_done, in_valid, out_ready,
        output load_en, in_ready, mac_en, out_valid, out_idx,
               weights_valid, busy, err, vec_cnt
    );

    modport master (
        output ena, start, reload, cfg_num_vec, load_done, in_valid, out_ready,
        input  load_en, in_ready, mac_en, out_valid, out_idx,
               weights_valid, busy, err, vec_cnt
    );

endinterface

// File: rtl/ternary_seq_ctrl_seq_down_counter.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
module seq_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Phase sequencer for the ternary matrix-vector tile: weight load, settle,
// per-vector MAC strobe, latency wait and lane-by-lane result emission.
module ternary_seq_ctrl
    import ternary_seq_ctrl_pkg::*;
#(
    parameter int unsigned MAC_LAT = DEF_MAC_LAT
) (
    input logic               clk,
    input logic               rst_n,
    ternary_seq_ctrl_if.slave bus
);

    seq_state_e       state, state_n;
    logic             wv_q, wv_n;
    logic             err_q, err_n;
    logic [VEC_W-1:0] vec_q, vec_n;
    logic [VEC_W-1:0] num_q, num_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [VEC_W-1:0] vec_inc;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // One counter serves both phases: load beats remaining, then MAC latency remaining.
    seq_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign vec_inc = sat_inc(vec_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wv_q  <= 1'b0;
            err_q <= 1'b0;
            vec_q <= '0;
            num_q <= '0;
            idx_q <= '0;
        end else begin
            state <= state_n;
            wv_q  <= wv_n;
            err_q <= err_n;
            vec_q <= vec_n;
            num_q <= num_n;
            idx_q <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        wv_n     = wv_q;
        err_n    = err_q;
        vec_n    = vec_q;
        num_n    = num_q;
        idx_n    = idx_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.ena && bus.start) begin
                    state_n  = S_LOAD;
                    wv_n     = 1'b0;
                    err_n    = 1'b0;
                    vec_n    = '0;
                    num_n    = bus.cfg_num_vec;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(LOAD_CYCLES - 1);
                end
            end
            S_LOAD: begin
                if (!bus.ena) begin
                    state_n = S_IDLE;
                end else if (bus.load_done) begin
                    if (cnt_zero) begin
                        state_n = S_SETTLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end
                end else if (cnt_zero) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SETTLE: begin
                if (bus.ena) begin
                    wv_n    = 1'b1;
                    state_n = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (bus.ena) begin
                    if (bus.reload) begin
                        state_n  = S_LOAD;
                        wv_n     = 1'b0;
                        err_n    = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(LOAD_CYCLES - 1);
                    end else if (bus.in_valid) begin
                        idx_n = '0;
                        if (MAC_LAT <= 1) begin
                            state_n = S_EMIT;
                        end else begin
                            state_n  = S_DRAIN;
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(MAC_LAT - 1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Leave on the decrement that reaches zero so out_valid trails mac_en by MAC_LAT.
                if (bus.ena) begin
                    cnt_dec = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        state_n = S_EMIT;
                        idx_n   = '0;
                    end
                end
            end
            S_EMIT: begin
                if (bus.ena && bus.out_ready) begin
                    if (idx_q == IDX_W'(MAX_OUT_LEN - 1)) begin
                        idx_n = '0;
                        vec_n = vec_inc;
                        if ((num_q != '0) && (vec_inc == num_q)) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_WAIT_IN;
                        end
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.load_en       = (state == S_LOAD) && bus.ena;
    assign bus.in_ready      = (state == S_WAIT_IN) && bus.ena && !bus.reload;
    assign bus.mac_en        = bus.in_ready && bus.in_valid;
    assign bus.out_valid     = (state == S_EMIT) && bus.ena;
    assign bus.out_idx       = idx_q;
    assign bus.weights_valid = wv_q;
    assign bus.busy          = (state != S_IDLE);
    assign bus.err           = err_q;
    assign bus.vec_cnt       = vec_q;

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Directed bench for ternary_seq_ctrl: expected lanes queued at vector issue,
// popped and compared by an independent monitor on each result handshake.
module tb_ternary_seq_ctrl;
    import ternary_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [IDX_W-1:0] exp_q[$];

    ternary_seq_ctrl_if bus ();

    ternary_seq_ctrl #(.MAC_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        nxt();
        bus.start = 1'b0;
    endtask

    // Loader model: asserts load_done on beat done_beat; drops ena on beat abort_beat.
    task automatic run_load(input int done_beat, input int abort_beat, output int beats);
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.load_en) break;
            if (beats == abort_beat) bus.ena = 1'b0;
            bus.load_done = (beats == done_beat);
            beats++;
            nxt();
        end
        bus.load_done = 1'b0;
    endtask

    task automatic send_vec();
        int lat;
        bus.in_valid = 1'b1;
        for (int k = 0; k < int'(MAX_OUT_LEN); k++) exp_q.push_back(IDX_W'(k));
        @(negedge clk);
        chk("mac_en_on_accept", bus.mac_en, 1);
        nxt();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            nxt();
            lat++;
        end
        chk("mac_to_out_valid", lat, 2);
    endtask

    task automatic drain(input int stall_at);
        int taken;
        int stalls;
        logic stall;
        taken = 0;
        stalls = 0;
        for (int i = 0; i < 60; i++) begin
            if (taken == int'(MAX_OUT_LEN)) break;
            stall = (taken == stall_at) && (stalls < 5);
            bus.out_ready = !stall;
            @(negedge clk);
            if (stall) begin
                stalls++;
                chk("bp_out_valid", bus.out_valid, 1);
                chk("bp_out_idx", bus.out_idx, stall_at);
            end
            if (bus.out_valid && bus.out_ready) taken++;
            nxt();
        end
        bus.out_ready = 1'b0;
        chk("lanes_taken", taken, MAX_OUT_LEN);
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_lane", 1, 0);
            end else begin
                chk("sb_out_idx", bus.out_idx, exp_q.pop_front());
            end
        end
    end

    initial begin
        int beats;
        logic [31:0] outs;

        bus.ena = 1'b0; bus.start = 1'b0; bus.reload = 1'b0; bus.cfg_num_vec = '0;
        bus.load_done = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        outs = {bus.load_en, bus.in_ready, bus.mac_en, bus.out_valid, bus.out_idx,
                bus.weights_valid, bus.busy, bus.err, bus.vec_cnt};
        chk("reset_outputs", outs, 0);
        nxt();
        rst_n = 1'b1;

        // Session 1: one vector, cfg_num_vec = 1
        bus.ena = 1'b1;
        bus.cfg_num_vec = 8'd1;
        nxt();
        pulse_start();
        run_load(15, 99, beats);
        chk("load_en_cycles", beats, 16);
        @(negedge clk);
        chk("settle_wv", bus.weights_valid, 0);
        chk("settle_in_ready", bus.in_ready, 0);
        nxt();
        chk("wait_wv", bus.weights_valid, 1);
        chk("wait_in_ready", bus.in_ready, 1);
        send_vec();
        drain(99);
        chk("s1_busy", bus.busy, 0);
        chk("s1_vec_cnt", bus.vec_cnt, 1);
        chk("s1_wv_kept", bus.weights_valid, 1);

        // Session 2: unlimited vectors, backpressure, freeze, reload race
        bus.cfg_num_vec = 8'd0;
        pulse_start();
        chk("s2_vec_cnt_clr", bus.vec_cnt, 0);
        chk("s2_wv_clr", bus.weights_valid, 0);
        run_load(15, 99, beats);
        nxt();
        send_vec();
        drain(3);
        chk("s2_busy", bus.busy, 1);
        chk("s2_vec_cnt", bus.vec_cnt, 1);
        chk("s2_in_ready", bus.in_ready, 1);

        bus.ena = 1'b0;
        @(negedge clk);
        chk("frz_in_ready", bus.in_ready, 0);
        chk("frz_busy", bus.busy, 1);
        nxt();
        bus.ena = 1'b1;
        @(negedge clk);
        chk("unfrz_in_ready", bus.in_ready, 1);
        nxt();

        bus.reload = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("race_in_ready", bus.in_ready, 0);
        chk("race_mac_en", bus.mac_en, 0);
        nxt();
        bus.reload = 1'b0;
        bus.in_valid = 1'b0;
        chk("race_load_en", bus.load_en, 1);
        chk("race_wv", bus.weights_valid, 0);
        run_load(15, 99, beats);
        chk("reload_cycles", beats, 16);
        nxt();
        send_vec();
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            nxt();
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {bus.load_en, bus.in_ready, bus.mac_en, bus.out_valid, bus.out_idx,
                bus.weights_valid, bus.busy, bus.err, bus.vec_cnt};
        chk("async_reset_outputs", outs, 0);
        chk("sb_left_at_reset", exp_q.size(), 5);
        exp_q.delete();
        bus.out_ready = 1'b0;
        nxt();
        rst_n = 1'b1;
        nxt();

        // Session 3: ena dropped at load beat 9
        bus.cfg_num_vec = 8'd1;
        pulse_start();
        run_load(99, 9, beats);
        bus.ena = 1'b1;
        chk("abort_beats", beats, 10);
        chk("abort_err", bus.err, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_wv", bus.weights_valid, 0);

        // Session 4: early load_done, then recovery
        pulse_start();
        run_load(7, 99, beats);
        chk("perr_beats", beats, 8);
        chk("perr_err", bus.err, 1);
        chk("perr_busy", bus.busy, 0);
        chk("perr_wv", bus.weights_valid, 0);
        pulse_start();
        chk("restart_err_clr", bus.err, 0);
        run_load(15, 99, beats);
        chk("restart_cycles", beats, 16);
        nxt();
        chk("restart_wv", bus.weights_valid, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ternary_seq_ctrl.md
Name: ternary_seq_ctrl

Overview:
Sequencer for the ternary matrix-vector tile. It drives the weight loader through a full 16-beat load, waits one settle cycle, then accepts one input vector per transaction. For each vector it strobes the MAC array, waits out the MAC latency, and emits MAX_OUT_LEN results one per handshake. It sits between the top-level pin interface and the loader/MAC datapath, and owns all phase sequencing.

Parameters:
MAX_IN_LEN, 16, input vector width (bits per beat into loader/MAC)
MAX_OUT_LEN, 8, output lanes; also sets load length
LOAD_CYCLES, 2*MAX_OUT_LEN, loader beats per full weight load (16)
MAC_LAT, 2, cycles from mac_en to results stable (>=1)
VEC_W, 8, width of vector-count config/counter

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  tile enable; low gates all strobes
start  in  1  pulse: begin load+compute session
reload  in  1  pulse: reload weights between vectors
cfg_num_vec  in  VEC_W  vectors per session; 0 = unlimited
load_en  out  1  drives loader ena
load_done  in  1  loader last-beat indication
in_valid  in  1  input vector present
in_ready  out  1  controller accepts vector
mac_en  out  1  one-cycle MAC compute strobe
out_valid  out  1  result lane valid
out_ready  in  1  consumer takes lane
out_idx  out  $clog2(MAX_OUT_LEN)  lane being presented
weights_valid  out  1  weights stable and usable
busy  out  1  state != IDLE
err  out  1  sticky load-protocol error
vec_cnt  out  VEC_W  vectors completed this session

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0, including counters, err and weights_valid.
- States: IDLE, LOAD, SETTLE, WAIT_IN, DRAIN, EMIT.
- IDLE: start & ena -> LOAD. Entering LOAD clears weights_valid, beat counter, vec_cnt and err.
- LOAD: load_en = ena. Beat counter increments each cycle.
  - load_done at beat LOAD_CYCLES-1 -> SETTLE.
  - load_done at any other beat, or beat counter reaches LOAD_CYCLES with no done: set err, go to IDLE.
  - ena low in LOAD aborts to IDLE. err is not set, weights_valid stays 0. (The loader resets its count when ena is low.)
- SETTLE: exactly 1 cycle; set weights_valid; -> WAIT_IN.
- WAIT_IN: in_ready = ena & !reload.
  - reload & ena -> LOAD. reload has priority over a simultaneous in_valid, and that vector is not accepted.
  - in_valid & in_ready: mac_en high for that same cycle (0 latency); -> DRAIN; latency counter loaded with MAC_LAT-1.
- DRAIN: count down; at 0 -> EMIT with out_idx=0.
- EMIT: out_valid = ena. Each cycle with out_valid & out_ready, out_idx increments.
  - On the handshake at out_idx = MAX_OUT_LEN-1, vec_cnt increments (saturates at all-ones).
  - If cfg_num_vec != 0 and the new vec_cnt == cfg_num_vec: -> IDLE, weights_valid kept.
  - Otherwise -> WAIT_IN.
  - out_idx and out_valid are held stable while out_ready is low.
- cfg_num_vec is sampled when entering LOAD from IDLE; later changes are ignored until the next session.
- ena low outside LOAD freezes state and counters; all strobes (in_ready, mac_en, out_valid) are 0.
- start outside IDLE is ignored. reload outside WAIT_IN is ignored.
- Strobes are combinational from registered state and ena; all state is registered.

Decomposition:
- Shared package: state enum typedef (3-bit encoding) and localparams for LOAD_CYCLES and lane-index width.
- One natural sub-module: seq_down_counter, a loadable down-counter with zero flag. It is reused for the load-beat count and for DRAIN latency.
- The FSM stays in the top.

Test Plan:
- Nominal load: rst_n low then high, ena=1, start pulse; loader model asserts load_done on beat 15 -> load_en high exactly 16 cycles, weights_valid rises 2 cycles after done, in_ready=1 on next cycle.
- One vector, MAC_LAT=2, cfg_num_vec=1: in_valid one cycle -> mac_en same cycle, out_valid 2 cycles later, out_idx 0..7 with out_ready=1, then busy=0 and vec_cnt=1.
- Backpressure: out_ready low for 5 cycles at out_idx=3 -> out_idx holds 3 and out_valid stays 1; on release, idx 4..7 complete.
- Protocol error: load_done at beat 7 -> err=1, state IDLE, weights_valid=0; a new start clears err.
- Reload race: in WAIT_IN assert reload and in_valid together -> in_ready=0, mac_en=0, load_en rises next cycle, weights_valid=0.
- ena/reset disruption: ena low at load beat 9 -> IDLE, err=0. Separately, rst_n low mid-EMIT -> all outputs 0 immediately (asynchronous, before the next clk edge).
